btn_event_queue: RTL
====================

BTN_EVENT_QUEUE -- requirements
Module: btn_event_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entry count (power of two, 2..16).
REQ-002 SHALL have parameter CNT_W, default 3, width of the occupancy count (clog2(DEPTH)+1).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port btn_evt  input  5  one-cycle button pulses from debouncers: [0] left, [1] right, [2] rotate, [3] down, [4] drop.
REQ-006 SHALL have port evt_ready  input  1  consumer (game FSM) accepts head event this cycle.
REQ-007 SHALL have port ovf_clr  input  1  clears the sticky overflow flag.
REQ-008 SHALL have port evt_valid  output  1  head entry present (count != 0).
REQ-009 SHALL have port evt_code  output  3  head event code, 1..5 = btn_evt bit index + 1; 0 when empty.
REQ-010 SHALL have port count  output  CNT_W  entries currently held, 0..DEPTH.
REQ-011 SHALL have port overflow  output  1  sticky flag, event lost.

Function
REQ-012 SHALL hold a 5-bit pending register: pending_next = (pending & ~grant) | btn_evt.
REQ-013 SHALL form grant as one-hot lowest set bit of pending when push is allowed, else zero.
REQ-014 SHALL allow push when pending != 0 and (count < DEPTH or pop in same cycle).
REQ-015 SHALL write code (granted index + 1) at the write pointer on push; one push per cycle maximum.
REQ-016 SHALL pop when evt_valid && evt_ready; advance read pointer; evt_ready while empty is ignored.
REQ-017 SHALL support simultaneous push and pop at any occupancy including full; count unchanged.
REQ-018 SHALL wrap read/write pointers modulo DEPTH.
REQ-019 SHALL give latency: pulse in cycle N with empty queue and empty pending -> evt_valid high in cycle N+2.
REQ-020 SHALL drive evt_code from storage at read pointer, forced to 0 when count == 0.
REQ-021 SHALL set overflow when a btn_evt bit is 1 while its pending bit is 1 and that bit is not granted that cycle.
REQ-022 SHALL clear overflow on ovf_clr; set wins when set and clear coincide.
REQ-023 SHALL, while full with no pop, stall pending (no grant) without losing events except per REQ-021.

Reset
REQ-024 SHALL on reset low asynchronously clear pending, pointers, count, overflow; evt_valid=0, evt_code=0, count=0, overflow=0.
REQ-025 SHALL discard all queued and pending events on reset mid-operation; storage contents need not be cleared.
REQ-026 SHALL ignore btn_evt, evt_ready, ovf_clr while reset is low.

Configuration
REQ-027 SHALL use macro BTN_QUEUE_COALESCE_EN.
REQ-028 SHALL, with BTN_QUEUE_COALESCE_EN defined, suppress a push (pending bit still cleared) when its code equals the most recently written entry and that entry is still in the FIFO and not popped that cycle.
REQ-029 SHALL, without BTN_QUEUE_COALESCE_EN, enqueue every granted event, duplicates included.

Verification
REQ-030 SHALL cover: reset release, btn_evt=5'b00001 in cycle 0, evt_ready=0 -> evt_valid=1, evt_code=1, count=1 from cycle 2.
REQ-031 SHALL cover: btn_evt=5'b10110 in one cycle, evt_ready=1 -> codes 2, 3, 5 delivered in order on consecutive cycles, overflow=0.
REQ-032 SHALL cover: DEPTH=4, six distinct pulses, evt_ready=0 -> count=4, remaining held pending; then evt_ready=1 -> all six codes delivered in arrival/priority order, overflow=0.
REQ-033 SHALL cover: full queue, pending bit 0 set, second pulse on bit 0 -> overflow=1; ovf_clr asserted same cycle as a new loss -> overflow stays 1; ovf_clr alone -> overflow=0.
REQ-034 SHALL cover: three entries queued, reset pulled low mid-stream -> evt_valid=0, count=0 immediately; after release, no old codes appear.
REQ-035 SHALL cover: BTN_QUEUE_COALESCE_EN defined, pulses on bit 1 in cycles 0 and 4, evt_ready=0 -> count=1, code 2; undefined -> count=2.

Source files
------------

// File: rtl/btn_event_queue.sv
// btn_event_queue: queues debounced button pulses for the game FSM.
// Lowest-index pending button is granted into a small FIFO each cycle.
//
// Ports:
//   clk        rising-edge clock
//   reset      async active-low reset
//   btn_evt    [4:0] one-cycle pulses: left,right,rotate,down,drop
//   evt_ready  consumer takes head event this cycle
//   ovf_clr    clears sticky overflow
//   evt_valid  head entry present
//   evt_code   head code 1..5 (bit index + 1), 0 when empty
//   count      entries held, 0..DEPTH
//   overflow   sticky, a pulse was lost
//
// Build option: define BTN_QUEUE_COALESCE_EN to drop a push whose code
// matches the newest entry still queued.
module btn_event_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       btn_evt,
  input  logic             evt_ready,
  input  logic             ovf_clr,
  output logic             evt_valid,
  output logic [2:0]       evt_code,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [2:0]       mem [DEPTH];
  logic [AW-1:0]    rptr;
  logic [AW-1:0]    wptr;
  logic [4:0]       pending;
  logic [4:0]       pend_nx;
  logic [4:0]       grant;
  logic [2:0]       grant_code;
  logic [CNT_W-1:0] cnt_nx;
  logic             pop;
  logic             room;
  logic             push;
  logic             dup;
  logic             wr_en;
  logic             loss;
  logic             ovf_nx;

  assign evt_valid = (count != '0);
  assign evt_code  = evt_valid ? mem[rptr] : 3'd0;

  assign pop  = evt_valid && evt_ready;
  assign room = (count < CNT_W'(DEPTH)) || pop;
  assign push = (pending != 5'd0) && room;

  // isolate lowest set bit of pending
  assign grant = push ? (pending & (~pending + 5'd1)) : 5'd0;

  always_comb begin
    grant_code = 3'd0;
    unique case (1'b1)
      grant[0]: grant_code = 3'd1;
      grant[1]: grant_code = 3'd2;
      grant[2]: grant_code = 3'd3;
      grant[3]: grant_code = 3'd4;
      grant[4]: grant_code = 3'd5;
      default:  grant_code = 3'd0;
    endcase
  end

`ifdef BTN_QUEUE_COALESCE_EN
  // newest entry sits just behind wptr; with one entry it is also
  // the head, so a same-cycle pop removes it and the push must go in
  assign dup = push
            && (count != '0)
            && (mem[wptr - AW'(1)] == grant_code)
            && !(pop && (count == CNT_W'(1)));
`else
  assign dup = 1'b0;
`endif

  assign wr_en = push && !dup;

  always_comb begin
    cnt_nx = count;
    unique case ({wr_en, pop})
      2'b10:   cnt_nx = count + CNT_W'(1);
      2'b01:   cnt_nx = count - CNT_W'(1);
      default: cnt_nx = count;
    endcase
  end

  // a pulse on a still-pending, ungranted bit merges and is lost
  assign loss    = |(btn_evt & pending & ~grant);
  assign ovf_nx  = loss | (overflow & ~ovf_clr);
  assign pend_nx = (pending & ~grant) | btn_evt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending  <= 5'd0;
      rptr     <= '0;
      wptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      pending  <= pend_nx;
      count    <= cnt_nx;
      overflow <= ovf_nx;
      if (pop)   rptr <= rptr + AW'(1);
      if (wr_en) wptr <= wptr + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= grant_code;
  end

endmodule
